// File: rtl/soc_sram_arb2.sv
// Two-master round-robin arbiter in front of one single-port SRAM. Grants are
// combinational; read data returns to the granted port one cycle later.
module soc_sram_arb2 #(
  parameter int XLEN      = 32,
  parameter int WORD_AW   = 30,
  parameter int MAX_BURST = 4,
  localparam int SW       = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [WORD_AW-1:0] m0_addr,
  input  logic [XLEN-1:0]    m0_din,
  input  logic [SW-1:0]      m0_sel,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [WORD_AW-1:0] m1_addr,
  input  logic [XLEN-1:0]    m1_din,
  input  logic [SW-1:0]      m1_sel,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [XLEN-1:0]    rdata,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [XLEN-1:0]    sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [XLEN-1:0]    sram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          rd_pend_q;
  logic          rd_port_q;
  logic          g0;
  logic          g1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // The owner keeps the grant until it has used MAX_BURST slots while the
  // other port waits; an idle tie goes to the port that did not own last.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      OWN0: begin
        if (m0_req && (cnt < CNT_MAX || !m1_req)) g0 = 1'b1;
        else                                      g1 = m1_req;
      end
      OWN1: begin
        if (m1_req && (cnt < CNT_MAX || !m0_req)) g1 = 1'b1;
        else                                      g0 = m0_req;
      end
      default: begin
        if (m0_req && m1_req) begin
          g0 = last;
          g1 = !last;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      rd_pend_q <= (g0 && !m0_we) || (g1 && !m1_we);
      rd_port_q <= g1;
      if (g0) begin
        state <= OWN0;
        last  <= 1'b0;
        cnt   <= (state == OWN0) ? sat_inc(cnt) : CNT_ONE;
      end else if (g1) begin
        state <= OWN1;
        last  <= 1'b1;
        cnt   <= (state == OWN1) ? sat_inc(cnt) : CNT_ONE;
      end else begin
        state <= IDLE;
      end
    end
  end

  // SRAM side: pass the granted port through, drive zeros when idle
  assign sram_ce    = g0 || g1;
  assign sram_we    = (g0 && m0_we) || (g1 && m1_we);
  assign sram_oe    = (g0 && !m0_we) || (g1 && !m1_we);
  assign sram_waddr = g0 ? m0_addr : (g1 ? m1_addr : '0);
  assign sram_din   = g0 ? m0_din  : (g1 ? m1_din  : '0);
  assign sram_sel   = g0 ? m0_sel  : (g1 ? m1_sel  : '0);

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rd_pend_q && !rd_port_q;
  assign m1_rvalid = rd_pend_q && rd_port_q;
  assign rdata     = sram_dout;

endmodule

// File: tb/tb_soc_sram_arb2.sv
// Randomized scoreboard bench for soc_sram_arb2 with a behavioural SRAM and
// an arbitration reference model based on per-port grant streaks.
module tb_soc_sram_arb2;
  localparam int XLEN      = 32;
  localparam int WORD_AW   = 30;
  localparam int MAX_BURST = 4;
  localparam int SW        = XLEN / 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               m0_req, m0_we, m1_req, m1_we;
  logic [WORD_AW-1:0] m0_addr, m1_addr;
  logic [XLEN-1:0]    m0_din, m1_din;
  logic [SW-1:0]      m0_sel, m1_sel;
  logic               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [XLEN-1:0]    rdata;
  logic               sram_ce, sram_we, sram_oe;
  logic [WORD_AW-1:0] sram_waddr;
  logic [XLEN-1:0]    sram_din;
  logic [SW-1:0]      sram_sel;
  logic [XLEN-1:0]    sram_dout;

  always #5 clk = ~clk;

  soc_sram_arb2 #(.XLEN(XLEN), .WORD_AW(WORD_AW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din), .m0_sel(m0_sel),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din), .m1_sel(m1_sel),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_waddr(sram_waddr), .sram_din(sram_din), .sram_sel(sram_sel),
    .sram_dout(sram_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i * 257));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] w;
    w = base;
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // Behavioural single-port SRAM: 64 words, unwritten words read as init_word
  bit [31:0] sram_mem [64];
  bit        sram_wr  [64];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        sram_mem[sram_waddr[5:0]] <= merge(sram_wr[sram_waddr[5:0]] ? sram_mem[sram_waddr[5:0]]
                                           : init_word(int'(sram_waddr[5:0])), sram_din, sram_sel);
        sram_wr[sram_waddr[5:0]]  <= 1'b1;
      end else if (sram_oe) begin
        sram_dout <= sram_wr[sram_waddr[5:0]] ? sram_mem[sram_waddr[5:0]]
                                              : init_word(int'(sram_waddr[5:0]));
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state
  typedef struct {int due; bit port; logic [31:0] data;} exp_t;
  exp_t        sbq[$];
  logic [31:0] ref_mem [64];
  int          prev   = -1;
  int          streak = 0;
  bit          last   = 1'b1;
  int          last_g = -1;

  // Pending requests per port, held until granted
  bit          pact [2];
  bit          pwe  [2];
  logic [WORD_AW-1:0] paddr [2];
  logic [31:0] pdin [2];
  logic [3:0]  psel [2];
  int          gen_prob [2];
  int          rv0_cnt = 0;

  function automatic int exp_grant(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (prev >= 0)  return (streak < MAX_BURST) ? prev : 1 - prev;
    return last ? 0 : 1;
  endfunction

  task automatic issue(input int p, input bit we, input int addr, input logic [31:0] d,
                       input logic [3:0] sel);
    pact[p] = 1'b1; pwe[p] = we; paddr[p] = WORD_AW'(addr); pdin[p] = d; psel[p] = sel;
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (!pact[p] && int'($urandom_range(99, 0)) < gen_prob[p])
        issue(p, bit'($urandom_range(1, 0)), int'($urandom_range(63, 40)), $urandom,
              4'($urandom_range(15, 0)));
    end
    m0_req = pact[0]; m0_we = pwe[0]; m0_addr = paddr[0]; m0_din = pdin[0]; m0_sel = psel[0];
    m1_req = pact[1]; m1_we = pwe[1]; m1_addr = paddr[1]; m1_din = pdin[1]; m1_sel = psel[1];
  endtask

  task automatic check_update();
    int g;
    int a;
    g = exp_grant(m0_req, m1_req);
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    chk("sram_ce", sram_ce, g >= 0);
    if (g >= 0) begin
      chk("sram_we", sram_we, pwe[g]);
      chk("sram_oe", sram_oe, !pwe[g]);
      chk("sram_waddr", sram_waddr, paddr[g]);
      chk("sram_din", sram_din, pdin[g]);
      chk("sram_sel", sram_sel, psel[g]);
      streak = (prev == g) ? streak + 1 : 1;
      prev   = g;
      last   = (g == 1);
      a      = int'(paddr[g][5:0]);
      if (pwe[g]) ref_mem[a] = merge(ref_mem[a], pdin[g], psel[g]);
      else        sbq.push_back('{due: cyc + 1, port: (g == 1), data: ref_mem[a]});
      pact[g] = 1'b0;
    end else begin
      chk("idle_strobes", {sram_we, sram_oe, sram_waddr, sram_din, sram_sel}, '0);
      prev = -1;
    end
    last_g = g;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pact[0] = 1'b0; pact[1] = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    sbq.delete();
    prev = -1; streak = 0; last = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rst_ce", {sram_ce, sram_we, sram_oe}, 3'b000);
    rst = 1'b1;
  endtask

  // Monitor: compares every returned read against the scoreboard
  initial begin
    logic [1:0] want;
    forever begin
      @(negedge clk); #1;
      want = 2'b00;
      if (sbq.size() > 0 && sbq[0].due <= cyc) want = sbq[0].port ? 2'b01 : 2'b10;
      chk("rvalid", {m0_rvalid, m1_rvalid}, want);
      if (m0_rvalid && rst) rv0_cnt++;
      if (want != 2'b00) begin
        chk("rdata", rdata, sbq[0].data);
        void'(sbq.pop_front());
      end
    end
  end

  int gs [9];
  int exp_pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int base;

  initial begin
    rst = 1'b0;
    gen_prob[0] = 0; gen_prob[1] = 0;
    for (int p = 0; p < 2; p++) issue(p, 1'b0, 0, 32'h0, 4'h0);
    pact[0] = 1'b0; pact[1] = 1'b0;
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = '0; m1_addr = '0;
    m0_din = '0; m1_din = '0; m0_sel = '0; m1_sel = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    do_reset();

    // Port 0 reads 0x10
    issue(0, 1'b0, 'h10, 32'h0, 4'hF);
    cycle();
    chk("t1_gnt", 32'(last_g), 32'd0);
    cycle();
    chk("t1_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t1_rdata", rdata, 32'hDEADBEEF);

    // First tie after reset goes to port 0, then port 1
    do_reset();
    issue(0, 1'b0, 1, 32'h0, 4'hF);
    issue(1, 1'b0, 2, 32'h0, 4'hF);
    cycle();
    chk("t2_first", 32'(last_g), 32'd0);
    cycle();
    chk("t2_second", 32'(last_g), 32'd1);

    // Both ports hold requests: bursts of MAX_BURST
    do_reset();
    gen_prob[0] = 100; gen_prob[1] = 100;
    for (int i = 0; i < 9; i++) begin
      cycle();
      gs[i] = last_g;
    end
    for (int i = 0; i < 9; i++) chk($sformatf("t3_pat%0d", i), 32'(gs[i]), 32'(exp_pat[i]));
    gen_prob[0] = 0; gen_prob[1] = 0;
    for (int i = 0; i < 20 && (pact[0] || pact[1]); i++) cycle();
    chk("t3_drain", {pact[0], pact[1]}, 2'b00);

    // Partial write then read back
    issue(1, 1'b1, 'h20, 32'h12345678, 4'b0011);
    cycle();
    chk("t4_wgnt", 32'(last_g), 32'd1);
    issue(1, 1'b0, 'h20, 32'h0, 4'hF);
    cycle();
    cycle();
    chk("t4_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("t4_rdata", rdata, 32'hC0DE5678);

    // Port 0 streams 10 reads alone
    cycle(); #2;
    base = rv0_cnt;
    for (int i = 0; i < 10; i++) begin
      issue(0, 1'b0, int'($urandom_range(63, 40)), 32'h0, 4'hF);
      cycle();
      chk("t5_gnt", 32'(last_g), 32'd0);
    end
    chk("t5_cnt", 32'(dut.cnt), 32'(MAX_BURST));
    cycle(); #2;
    chk("t5_rvalids", 32'(rv0_cnt - base), 32'd10);

    // Reset in the cycle after a read grant drops the return
    issue(0, 1'b0, 'h10, 32'h0, 4'hF);
    cycle();
    chk("t6_gnt", 32'(last_g), 32'd0);
    @(posedge clk); #1;
    do_reset();
    cycle();
    chk("t6_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    issue(0, 1'b0, 3, 32'h0, 4'hF);
    issue(1, 1'b0, 4, 32'h0, 4'hF);
    cycle();
    chk("t6_tie", 32'(last_g), 32'd0);

    // Randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      gen_prob[0] = int'($urandom_range(100, 20));
      gen_prob[1] = int'($urandom_range(100, 20));
      for (int i = 0; i < 50; i++) cycle();
    end
    gen_prob[0] = 0; gen_prob[1] = 0;
    for (int i = 0; i < 20 && (pact[0] || pact[1]); i++) cycle();
    chk("rand_drain", {pact[0], pact[1]}, 2'b00);
    repeat (3) cycle();
    #2;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/soc_sram_arb2.md
# soc_sram_arb2

Two-port round-robin arbiter and sequencer in front of one single-port SRAM instance (`soc_sram_sp`), so that two masters (e.g. instruction fetch and data load/store) share one memory. Each cycle it grants at most one request, drives the SRAM strobe, address, data and byte-select lines, and returns read data to the granted port one cycle later. A bounded burst-ownership counter lets one master stream back-to-back accesses without starving the other.

## Interface
Parameters:
- `XLEN`, 32: data width. Valid values are 32, 16 and 8. `SW = XLEN/8`.
- `WORD_AW`, 30: SRAM word address width.
- `MAX_BURST`, 4: maximum consecutive grants to one port while the other port is requesting. Must be at least 1.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `mN_req`  in  1: access request from port N (N = 0, 1).
- `mN_we`  in  1: 1 = write, 0 = read.
- `mN_addr`  in  WORD_AW: word address.
- `mN_din`  in  XLEN: write data.
- `mN_sel`  in  SW: byte selects.
- `mN_gnt`  out  1: request accepted this cycle (combinational).
- `mN_rvalid`  out  1: `rdata` is valid for port N.
- `rdata`  out  XLEN: read data, shared by both ports. Equal to `sram_dout`.
- `sram_ce`, `sram_we`, `sram_oe`  out  1: SRAM strobes.
- `sram_waddr`  out  WORD_AW: SRAM word address.
- `sram_din`  out  XLEN: SRAM write data.
- `sram_sel`  out  SW: SRAM byte selects.
- `sram_dout`  in  XLEN: SRAM read data, valid one cycle after a read strobe.

## Operation
- FSM states are IDLE, OWN0 and OWN1. State `last` (1 bit) records the most recent owner. `cnt` is a saturating counter of width `$clog2(MAX_BURST+1)`.
- IDLE:
  - Only one port requesting: grant it.
  - Both ports requesting: grant the port that is not `last`.
  - On any grant: go to OWNx, set `cnt=1`, set `last=x`.
- OWNx, where y is the other port:
  - `mx_req && (cnt<MAX_BURST || !my_req)`: grant x. `cnt` increments and saturates at `MAX_BURST`.
  - Otherwise, if `my_req`: grant y, go to OWNy, set `cnt=1`, set `last=y`.
  - Otherwise: no grant, go to IDLE. `cnt` is held.
- At most one `mN_gnt` is high per cycle. A grant is never issued without the matching `mN_req`.
- Granted cycle:
  - `sram_ce=1`, `sram_we=mN_we`, `sram_oe=!mN_we`.
  - Address, write data and byte selects pass through from the granted port.
- No-grant cycle: `sram_ce=sram_we=sram_oe=0`. Address, data and selects are 0.
- Read return: registered flag `rd_port_q`/`rd_pend_q`. `mN_rvalid=1` exactly in the cycle after port N was granted a read. Writes never produce `rvalid`.
- A port may issue a new request in the same cycle its earlier read returns. Pipelined back-to-back reads give one `rvalid` per cycle.
- Requesters must hold `req`, `we`, `addr`, `din` and `sel` stable until `gnt`.

## Timing
- Grant latency: 0 cycles. Grant is combinational from `req` and current state.
- Read latency: 1 cycle from grant to `rvalid` + `rdata`.
- Write: completes at the granted edge. Throughput is 1 access per cycle total.
- Reset values (rst low, asynchronous):
  - State IDLE, `last=1` (so port 0 wins the first tie), `cnt=0`.
  - `rd_pend_q=0`, so both `mN_rvalid` outputs are 0.
  - Combinational outputs follow IDLE with no requests held: all `gnt` and SRAM strobes are 0.
- Reset asserted mid-read: the pending `rvalid` is dropped and never emitted after reset release.
- A simultaneous request, for example port 0 bursting while port 1 arrives, is resolved by the `cnt`/`MAX_BURST` rule. Port 1 waits at most `MAX_BURST` cycles.
- `cnt` saturation: one port streaming alone keeps `cnt=MAX_BURST` and keeps its grant every cycle.

## Test plan
- Reset, then port 0 reads address 0x10 whose contents are 0xDEADBEEF:
  - `m0_gnt=1` in cycle 0.
  - `m0_rvalid=1` and `rdata=0xDEADBEEF` in cycle 1.
  - `m1_rvalid=0` throughout.
- Both ports request in the first cycle after reset: port 0 is granted first. After port 0 drops its request, port 1 is granted in the next cycle.
- `MAX_BURST=4`, both ports holding requests continuously: the grant pattern is 0,0,0,0,1,1,1,1,0,… with no idle cycles.
- Port 1 writes 0x12345678 with `sel=4'b0011` to address 0x20, then reads 0x20: `rdata` bits [15:0] are 0x5678 and the upper bytes are unchanged.
- Port 0 alone streams 10 reads: 10 consecutive grants, 10 `m0_rvalid` pulses, and `cnt` stays at 4.
- Assert `rst` in the cycle after a read grant: `m0_rvalid` stays 0. After release, state is IDLE and the first tie goes to port 0.
